// File: rtl/mdu_pkg.sv
// Shared types for the multiply/divide unit: op encoding, FSM states,
// default width and counter width.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;
    localparam int MDU_CNT_W = $clog2(MDU_WIDTH);

    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MTHI  = 3'd4,
        MTLO  = 3'd5
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mdu_state_t;

    function automatic logic mdu_is_signed(input mdu_op_t op);
        return (op == MULT) || (op == DIV);
    endfunction

endpackage

// File: rtl/mult_div_ctrl_if.sv
// Execute-stage <-> MDU bundle.
// master: execute/hazard side (drives start/op/a/b/flush/mf_req).
// slave : MDU side (drives busy/done/stall/hi/lo).
interface mult_div_ctrl_if
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) ();

    logic             start;
    mdu_op_t          op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             mf_req;
    logic             busy;
    logic             done;
    logic             stall;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush, mf_req,
        input  busy, done, stall, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush, mf_req,
        output busy, done, stall, hi, lo
    );

endinterface

// File: rtl/mdu_step.sv
// One combinational MDU iteration: shift-add multiply step or
// restoring shift-subtract divide step, chosen by is_div.
// Ports: p_hi/p_lo accumulator, mc multiplicand/divisor,
// mr remaining multiplier bits; *_n are next-iteration values.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [WIDTH-1:0]   p_hi,
    input  logic [WIDTH-1:0]   p_lo,
    input  logic [2*WIDTH-1:0] mc,
    input  logic [WIDTH-1:0]   mr,
    output logic [WIDTH-1:0]   p_hi_n,
    output logic [WIDTH-1:0]   p_lo_n,
    output logic [2*WIDTH-1:0] mc_n,
    output logic [WIDTH-1:0]   mr_n
);

    logic [WIDTH:0]     rem_s;
    logic [WIDTH:0]     diff;
    logic               ge;
    logic [2*WIDTH-1:0] sum;

    always_comb begin
        // Partial remainder < divisor, so 2*rem+1 fits in WIDTH+1
        // bits and the difference's top bit is its sign.
        rem_s  = {p_hi, p_lo[WIDTH-1]};
        diff   = rem_s - {1'b0, mc[WIDTH-1:0]};
        ge     = ~diff[WIDTH];
        sum    = {p_hi, p_lo} + mc;
        p_hi_n = p_hi;
        p_lo_n = p_lo;
        mc_n   = mc;
        mr_n   = mr;
        if (is_div) begin
            p_hi_n = ge ? diff[WIDTH-1:0] : rem_s[WIDTH-1:0];
            p_lo_n = {p_lo[WIDTH-2:0], ge};
        end else begin
            if (mr[0]) begin
                {p_hi_n, p_lo_n} = sum;
            end
            mc_n = mc << 1;
            mr_n = mr >> 1;
        end
    end

endmodule

// File: rtl/mult_div_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO; also MTHI/MTLO.
// Ports: clk, reset (sync, active-high), bus (mult_div_ctrl_if.slave).
// Optional macro MDU_EARLY_TERM_EN: multiply leaves CALC once the
// remaining multiplier bits are zero.
module mult_div_ctrl
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    mult_div_ctrl_if.slave   bus
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mdu_state_t         state_q;
    mdu_state_t         state_n;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   p_hi_q;
    logic [WIDTH-1:0]   p_lo_q;
    logic [2*WIDTH-1:0] mc_q;
    logic [WIDTH-1:0]   mr_q;
    logic               is_div_q;
    logic               neg_q_q;
    logic               neg_r_q;
    logic               dz_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;

    logic [WIDTH-1:0]   p_hi_n;
    logic [WIDTH-1:0]   p_lo_n;
    logic [2*WIDTH-1:0] mc_n;
    logic [WIDTH-1:0]   mr_n;

    logic               ld_mul;
    logic               ld_div;
    logic               wr_hi;
    logic               wr_lo;
    logic               step_en;
    logic               fix_en;
    logic               early;

    logic               sgn;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div (is_div_q),
        .p_hi   (p_hi_q),
        .p_lo   (p_lo_q),
        .mc     (mc_q),
        .mr     (mr_q),
        .p_hi_n (p_hi_n),
        .p_lo_n (p_lo_n),
        .mc_n   (mc_n),
        .mr_n   (mr_n)
    );

    always_comb begin
        sgn   = mdu_is_signed(bus.op);
        a_neg = sgn & bus.a[WIDTH-1];
        b_neg = sgn & bus.b[WIDTH-1];
        a_mag = a_neg ? -bus.a : bus.a;
        b_mag = b_neg ? -bus.b : bus.b;
    end

    always_comb begin
        prod     = {p_hi_q, p_lo_q};
        prod_fix = neg_q_q ? -prod : prod;
        q_fix    = neg_q_q ? -p_lo_q : p_lo_q;
        r_fix    = neg_r_q ? -p_hi_q : p_hi_q;
    end

`ifdef MDU_EARLY_TERM_EN
    assign early = ~is_div_q & (mr_n == '0);
`else
    assign early = 1'b0;
`endif

    always_comb begin
        state_n = state_q;
        ld_mul  = 1'b0;
        ld_div  = 1'b0;
        wr_hi   = 1'b0;
        wr_lo   = 1'b0;
        step_en = 1'b0;
        fix_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // flush kills anything presented alongside it
                if (bus.start && !bus.flush) begin
                    unique case (1'b1)
                        (bus.op == MTHI): wr_hi = 1'b1;
                        (bus.op == MTLO): wr_lo = 1'b1;
                        (bus.op == MULT),
                        (bus.op == MULTU): begin
                            ld_mul  = 1'b1;
                            state_n = CALC;
                        end
                        (bus.op == DIV),
                        (bus.op == DIVU): begin
                            ld_div  = 1'b1;
                            state_n = CALC;
                        end
                        default: ;
                    endcase
                end
            end
            CALC: begin
                if (bus.flush) begin
                    state_n = IDLE;
                end else begin
                    step_en = 1'b1;
                    if (cnt_q == LAST || early) begin
                        state_n = FIX;
                    end
                end
            end
            FIX: begin
                state_n = IDLE;
                fix_en  = ~bus.flush;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            p_hi_q   <= '0;
            p_lo_q   <= '0;
            mc_q     <= '0;
            mr_q     <= '0;
            is_div_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            dz_q     <= 1'b0;
            a_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (wr_hi) begin
                hi_q <= bus.a;
            end
            if (wr_lo) begin
                lo_q <= bus.a;
            end
            if (ld_mul) begin
                cnt_q    <= '0;
                p_hi_q   <= '0;
                p_lo_q   <= '0;
                mc_q     <= {{WIDTH{1'b0}}, a_mag};
                mr_q     <= b_mag;
                is_div_q <= 1'b0;
                neg_q_q  <= a_neg ^ b_neg;
                neg_r_q  <= 1'b0;
                dz_q     <= 1'b0;
                a_q      <= bus.a;
            end
            if (ld_div) begin
                cnt_q    <= '0;
                p_hi_q   <= '0;
                p_lo_q   <= a_mag;
                mc_q     <= {{WIDTH{1'b0}}, b_mag};
                mr_q     <= '0;
                is_div_q <= 1'b1;
                neg_q_q  <= a_neg ^ b_neg;
                neg_r_q  <= a_neg;
                dz_q     <= (bus.b == '0);
                a_q      <= bus.a;
            end
            if (step_en) begin
                cnt_q  <= cnt_q + CW'(1);
                p_hi_q <= p_hi_n;
                p_lo_q <= p_lo_n;
                mc_q   <= mc_n;
                mr_q   <= mr_n;
            end
            if (fix_en) begin
                done_q <= 1'b1;
                if (!is_div_q) begin
                    {hi_q, lo_q} <= prod_fix;
                end else if (dz_q) begin
                    // divide by zero reports the raw dividend
                    lo_q <= '1;
                    hi_q <= a_q;
                end else begin
                    lo_q <= q_fix;
                    hi_q <= r_fix;
                end
            end
        end
    end

    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = done_q;
    assign bus.stall = (bus.mf_req | bus.start) & bus.busy;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

endmodule
